// File: rtl/seq_count_bcd2_ctrl_if.sv
// Handshake and data bundle for the two-digit BCD run controller.
// The master side drives control and target digits.
// The slave side (the controller) returns the count digits and the status flags.
interface seq_count_bcd2_ctrl_if;
    logic       clear;
    logic       start;
    logic       stop;
    logic [3:0] target_tens;
    logic [3:0] target_ones;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic       busy;
    logic       done;

    modport master (
        output clear, start, stop, target_tens, target_ones,
        input  out_tens, out_ones, busy, done
    );

    modport slave (
        input  clear, start, stop, target_tens, target_ones,
        output out_tens, out_ones, busy, done
    );
endinterface

// File: rtl/seq_count_bcd2_ctrl.sv
// Two-digit (00-99) BCD run controller.
// It uses cascaded ones/tens decade counters, sequenced by an IDLE/RUN/PAUSE/DONE FSM.
// Counting stops at a target value, which is latched and clamped to 99 on each accepted start.
//
// Optional build macro SEQ_COUNT_BCD2_CTRL_AUTO_RELOAD_EN:
// when defined, reaching the target reloads the count to 00 and the FSM stays in RUN.
// In that build, done pulses for the single cycle in which the wrapped 00 is shown.
module seq_count_bcd2_ctrl (
    input  logic                       clk,
    input  logic                       reset,
    seq_count_bcd2_ctrl_if.slave       bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_q,    state_d;
    logic [3:0] tens_q,     tens_d;
    logic [3:0] ones_q,     ones_d;
    logic [3:0] tgt_tens_q, tgt_tens_d;
    logic [3:0] tgt_ones_q, tgt_ones_d;
    logic       at_target;
`ifdef SEQ_COUNT_BCD2_CTRL_AUTO_RELOAD_EN
    logic       wrap_q,     wrap_d;
`endif

    // Any target digit above 9 is treated as 9, so the count can always reach the target.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign at_target = ({tens_q, ones_q} == {tgt_tens_q, tgt_ones_q});

    // Next-state and next-count logic; clear overrides every state.
    always_comb begin
        // NOTE: every variable gets a hold value first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tgt_tens_d = tgt_tens_q;
        tgt_ones_d = tgt_ones_q;
`ifdef SEQ_COUNT_BCD2_CTRL_AUTO_RELOAD_EN
        wrap_d     = 1'b0;
`endif

        if (bus.clear) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        tgt_tens_d = clamp_digit(bus.target_tens);
                        tgt_ones_d = clamp_digit(bus.target_ones);
                        tens_d     = 4'd0;
                        ones_d     = 4'd0;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (at_target) begin
`ifdef SEQ_COUNT_BCD2_CTRL_AUTO_RELOAD_EN
                        tens_d = 4'd0;
                        ones_d = 4'd0;
                        wrap_d = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end else if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        // Wrap from 99 to 00 cannot be reached with a clamped target.
                        // It is kept so the counter never leaves the BCD range.
                        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and target registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample the pre-edge
        // values, independent of statement order inside this block.
        if (reset) begin
            state_q    <= ST_IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            tgt_tens_q <= 4'd0;
            tgt_ones_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tgt_tens_q <= tgt_tens_d;
            tgt_ones_q <= tgt_ones_d;
        end
    end

`ifdef SEQ_COUNT_BCD2_CTRL_AUTO_RELOAD_EN
    // Marks the cycle in which the reloaded 00 is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.done = wrap_q;
`else
    assign bus.done = (state_q == ST_DONE);
`endif

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.out_tens = tens_q;
    assign bus.out_ones = ones_q;

endmodule
